// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller: coin codes, coin values,
// state encodings and the default price table.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_ONE  = 2'b01;
  localparam logic [1:0] COIN_TWO  = 2'b10;
  localparam logic [1:0] COIN_FIVE = 2'b11;

  localparam logic [31:0] DEFAULT_PRICES = {8'd5, 8'd4, 8'd3, 8'd2};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CREDIT = 3'd1,
    S_VEND   = 3'd2,
    S_CHANGE = 3'd3,
    S_REJECT = 3'd4
  } state_e;

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      COIN_ONE:  v = 8'd1;
      COIN_TWO:  v = 8'd2;
      COIN_FIVE: v = 8'd5;
      default:   v = 8'd0;
    endcase
    return v;
  endfunction

  // Largest coin not exceeding the amount still owed.
  function automatic logic [1:0] change_coin(input logic [31:0] amount);
    logic [1:0] c;
    if (amount >= 32'd5) begin
      c = COIN_FIVE;
    end else if (amount >= 32'd2) begin
      c = COIN_TWO;
    end else if (amount >= 32'd1) begin
      c = COIN_ONE;
    end else begin
      c = COIN_NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/vend_edge_sync.sv
// Two-flop synchroniser for an asynchronous button followed by a registered
// rising-edge detector; a held button yields exactly one single-cycle pulse.
module vend_edge_sync
  import vend_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  // Next-state for the synchroniser chain and edge detector.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  // Synchroniser and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/soda_vend_multi.sv
// Multi-product vending controller: accumulates coin credit, vends one product at its
// own price and pays change back greedily, one coin per acknowledge.
module soda_vend_multi
  import vend_pkg::*;
#(
  parameter int N_PRODUCTS = 4,
  parameter logic [8*N_PRODUCTS-1:0] PRICES = DEFAULT_PRICES,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 20,
  localparam int SEL_W = $clog2(N_PRODUCTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  next,
  input  logic [1:0]            coin_in,
  input  logic                  buy,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  cancel,
  output logic [N_PRODUCTS-1:0] dispense,
  input  logic                  dispense_ack,
  output logic [1:0]            coin_out,
  input  logic                  coin_ack,
  output logic [CREDIT_W-1:0]   credit,
  output logic [2:0]            state_display,
  output logic                  check_coin_in
);

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  logic next_p, buy_p, cancel_p;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [N_PRODUCTS-1:0] dispense_q, dispense_d;
  logic [1:0]            coin_out_q, coin_out_d;

  logic [CREDIT_W:0]     sum_s;
  logic [CREDIT_W-1:0]   price_s;
  logic [CREDIT_W-1:0]   rem_s;
  logic                  sel_ok_s;
  int                    sel_idx_s;

  vend_edge_sync u_sync_next (
    .clk    (clk),
    .reset  (reset),
    .raw_in (next),
    .pulse  (next_p)
  );

  vend_edge_sync u_sync_buy (
    .clk    (clk),
    .reset  (reset),
    .raw_in (buy),
    .pulse  (buy_p)
  );

  vend_edge_sync u_sync_cancel (
    .clk    (clk),
    .reset  (reset),
    .raw_in (cancel),
    .pulse  (cancel_p)
  );

  // Transaction FSM: credit, vend request and payout coin next-state.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = dispense_q;
    coin_out_d = coin_out_q;
    sel_idx_s  = int'(sel);
    sel_ok_s   = (sel_idx_s < N_PRODUCTS);
    sum_s      = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_in));
    rem_s      = credit_q - CREDIT_W'(coin_value(coin_out_q));
    if (sel_ok_s) begin
      price_s = CREDIT_W'(PRICES[8*sel_idx_s +: 8]);
    end else begin
      price_s = {CREDIT_W{1'b1}};
    end

    case (state_q)
      S_IDLE, S_CREDIT: begin
        // Only one button acts per cycle: cancel beats buy beats next.
        if (cancel_p) begin
          if (state_q == S_CREDIT) begin
            state_d    = S_CHANGE;
            coin_out_d = change_coin(32'(credit_q));
          end else begin
            state_d = state_q;
          end
        end else if (buy_p) begin
          if (state_q == S_CREDIT && sel_ok_s && credit_q >= price_s) begin
            credit_d   = credit_q - price_s;
            dispense_d = {{(N_PRODUCTS-1){1'b0}}, 1'b1} << sel;
            state_d    = S_VEND;
          end else begin
            state_d = state_q;
          end
        end else if (next_p && coin_in != COIN_NONE) begin
          if (sum_s <= MAX_SUM) begin
            credit_d = sum_s[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end else begin
            coin_out_d = coin_in;
            state_d    = S_REJECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_VEND: begin
        if (dispense_ack) begin
          dispense_d = '0;
          if (credit_q != '0) begin
            state_d    = S_CHANGE;
            coin_out_d = change_coin(32'(credit_q));
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_VEND;
        end
      end
      S_CHANGE: begin
        if (credit_q == '0) begin
          coin_out_d = COIN_NONE;
          state_d    = S_IDLE;
        end else if (coin_ack) begin
          credit_d = rem_s;
          if (rem_s == '0) begin
            coin_out_d = COIN_NONE;
            state_d    = S_IDLE;
          end else begin
            coin_out_d = change_coin(32'(rem_s));
            state_d    = S_CHANGE;
          end
        end else begin
          state_d = S_CHANGE;
        end
      end
      S_REJECT: begin
        if (coin_ack) begin
          coin_out_d = COIN_NONE;
          if (credit_q != '0) begin
            state_d = S_CREDIT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_REJECT;
        end
      end
      default: begin
        state_d    = S_IDLE;
        dispense_d = '0;
        coin_out_d = COIN_NONE;
      end
    endcase
  end

  // State, credit and actuator output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      dispense_q <= '0;
      coin_out_q <= COIN_NONE;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      coin_out_q <= coin_out_d;
    end
  end

  assign dispense      = dispense_q;
  assign coin_out      = coin_out_q;
  assign credit        = credit_q;
  assign state_display = state_q;
  assign check_coin_in = (state_q == S_IDLE) || (state_q == S_CREDIT);

endmodule
